// File: rtl/collision_detector_pkg.sv
// Shared constants and encodings for the collision detector and its probe
// address generator.
package collision_detector_pkg;

    localparam int CHAR_X        = 72;
    localparam int CHAR_SIZE     = 16;
    localparam int TILE_SHIFT    = 3;
    localparam int MAP_COLS_LOG2 = 7;
    localparam int MAP_ROWS      = 15;
    localparam int NUM_PROBES    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_LAST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        PR_DOWN0  = 3'd0,
        PR_DOWN1  = 3'd1,
        PR_UP0    = 3'd2,
        PR_UP1    = 3'd3,
        PR_LEFT0  = 3'd4,
        PR_LEFT1  = 3'd5,
        PR_RIGHT0 = 3'd6,
        PR_RIGHT1 = 3'd7
    } probe_t;

endpackage

// File: rtl/collision_probe_addr.sv
// Maps a probe index and the latched character position to a tile RAM address,
// flagging probes that fall above or below the map.
module collision_probe_addr
    import collision_detector_pkg::*;
(
    input  logic [2:0]  probe_idx,
    input  logic [9:0]  px,
    input  logic [7:0]  py,
    output logic [10:0] tile_addr,
    output logic        oob
);

    logic [9:0] probe_x;
    logic [8:0] probe_y;
    logic       y_neg;
    logic [5:0] row;
    logic [6:0] col;

    // x wraps naturally in 10 bits; y carries a ninth bit so py+16 cannot alias
    always_comb begin
        probe_x = px;
        probe_y = {1'b0, py};
        y_neg   = 1'b0;
        case (probe_t'(probe_idx))
            PR_DOWN0: begin
                probe_x = px + 10'd1;
                probe_y = {1'b0, py} + 9'(CHAR_SIZE);
            end
            PR_DOWN1: begin
                probe_x = px + 10'(CHAR_SIZE - 2);
                probe_y = {1'b0, py} + 9'(CHAR_SIZE);
            end
            PR_UP0: begin
                probe_x = px + 10'd1;
                probe_y = {1'b0, py} - 9'd1;
                y_neg   = (py == 8'd0);
            end
            PR_UP1: begin
                probe_x = px + 10'(CHAR_SIZE - 2);
                probe_y = {1'b0, py} - 9'd1;
                y_neg   = (py == 8'd0);
            end
            PR_LEFT0: begin
                probe_x = px - 10'd1;
                probe_y = {1'b0, py} + 9'd1;
            end
            PR_LEFT1: begin
                probe_x = px - 10'd1;
                probe_y = {1'b0, py} + 9'(CHAR_SIZE - 2);
            end
            PR_RIGHT0: begin
                probe_x = px + 10'(CHAR_SIZE);
                probe_y = {1'b0, py} + 9'd1;
            end
            PR_RIGHT1: begin
                probe_x = px + 10'(CHAR_SIZE);
                probe_y = {1'b0, py} + 9'(CHAR_SIZE - 2);
            end
            default: ;
        endcase
    end

    assign row       = probe_y[8:TILE_SHIFT];
    assign col       = probe_x[9:TILE_SHIFT];
    assign oob       = y_neg || (row >= 6'(MAP_ROWS));
    assign tile_addr = {row[3:0], col};

endmodule

// File: rtl/collision_detector.sv
// Probes eight points around the character against the tile map and reports
// which of the four directions are blocked, using an enable/done handshake.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_IDLE  | waiting for enable; position is latched on exit
// ST_PROBE | 8 cycles, issue probe k, capture result of probe k-1
// ST_LAST  | capture probe 7, load all four flags together
// ST_DONE  | done high until enable drops
module collision_detector
    import collision_detector_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [9:0]  scroll_x,
    input  logic [7:0]  y_position,
    input  logic        tile_solid,
    output logic [10:0] tile_addr,
    output logic        tile_rd,
    output logic        left_blocked,
    output logic        right_blocked,
    output logic        up_blocked,
    output logic        down_blocked,
    output logic        done
);

    state_t      state, state_nxt;
    logic [2:0]  probe_k;
    logic [9:0]  px;
    logic [7:0]  py;
    logic [7:0]  hits;
    logic [7:0]  hits_final;
    logic        oob_prev;
    logic        hit_in;
    logic [10:0] addr_hold;
    logic [10:0] probe_addr;
    logic        probe_oob;

    collision_probe_addr u_probe_addr (
        .probe_idx (probe_k),
        .px        (px),
        .py        (py),
        .tile_addr (probe_addr),
        .oob       (probe_oob)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable) state_nxt = ST_PROBE;
            ST_PROBE: if (probe_k == 3'(NUM_PROBES - 1)) state_nxt = ST_LAST;
            ST_LAST:  state_nxt = ST_DONE;
            ST_DONE:  if (!enable) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Out-of-bounds slots skip the read; the address bus holds its last value
    always_comb begin
        tile_rd   = 1'b0;
        tile_addr = addr_hold;
        done      = 1'b0;
        case (state)
            ST_PROBE: begin
                tile_rd = !probe_oob;
                if (!probe_oob) tile_addr = probe_addr;
            end
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    assign hit_in     = oob_prev | tile_solid;
    assign hits_final = {hit_in, hits[6:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            probe_k       <= '0;
            px            <= '0;
            py            <= '0;
            hits          <= '0;
            oob_prev      <= 1'b0;
            addr_hold     <= '0;
            left_blocked  <= 1'b0;
            right_blocked <= 1'b0;
            up_blocked    <= 1'b0;
            down_blocked  <= 1'b0;
        end else begin
            if (state == ST_IDLE && enable) begin
                px <= scroll_x + 10'(CHAR_X);
                py <= y_position;
            end
            if (state == ST_PROBE) begin
                probe_k  <= probe_k + 3'd1;
                oob_prev <= probe_oob;
                if (probe_k != 3'd0) hits[probe_k - 3'd1] <= hit_in;
                if (!probe_oob) addr_hold <= probe_addr;
            end else begin
                probe_k <= '0;
            end
            if (state == ST_LAST) begin
                hits[7]       <= hit_in;
                down_blocked  <= hits_final[PR_DOWN0]  | hits_final[PR_DOWN1];
                up_blocked    <= hits_final[PR_UP0]    | hits_final[PR_UP1];
                left_blocked  <= hits_final[PR_LEFT0]  | hits_final[PR_LEFT1];
                right_blocked <= hits_final[PR_RIGHT0] | hits_final[PR_RIGHT1];
            end
        end
    end

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: directed scenarios plus random
// maps/positions, checked against a point-sampling model of the tile map.
module tb_collision_detector;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [9:0]  scroll_x = '0;
    logic [7:0]  y_position = '0;
    logic        tile_solid = 1'b0;
    logic [10:0] tile_addr;
    logic        tile_rd;
    logic        left_blocked, right_blocked, up_blocked, down_blocked;
    logic        done;

    int errors = 0;
    int checks = 0;
    logic map_bits [0:2047];
    logic [3:0] exp_flags;

    collision_detector dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .scroll_x      (scroll_x),
        .y_position    (y_position),
        .tile_solid    (tile_solid),
        .tile_addr     (tile_addr),
        .tile_rd       (tile_rd),
        .left_blocked  (left_blocked),
        .right_blocked (right_blocked),
        .up_blocked    (up_blocked),
        .down_blocked  (down_blocked),
        .done          (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (tile_rd) tile_solid <= map_bits[tile_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_oob(input int y);
        return (y < 0) || ((y / 8) >= 15);
    endfunction

    function automatic int m_addr(input int x, input int y);
        return (y / 8) * 128 + (((x % 1024) + 1024) % 1024) / 8;
    endfunction

    function automatic bit m_hit(input int x, input int y);
        if (m_oob(y)) return 1'b1;
        return map_bits[m_addr(x, y)];
    endfunction

    task automatic clear_map();
        for (int i = 0; i < 2048; i++) map_bits[i] = 1'b0;
    endtask

    task automatic random_map(input int pct);
        for (int i = 0; i < 2048; i++) map_bits[i] = ($urandom_range(0, 99) < pct);
    endtask

    function automatic logic [3:0] flags_now();
        return {right_blocked, left_blocked, up_blocked, down_blocked};
    endfunction

    // One transaction; enable set in cycle 0, observed #1 after each edge
    task automatic run_txn(input int sx, input int y, input bit drop_en);
        int px, py, last_addr;
        bit have_addr;
        int xs[8];
        int ys[8];
        bit [7:0] hit;
        px = (sx + 72) % 1024;
        py = y;
        xs = '{px + 1, px + 14, px + 1, px + 14, px - 1, px - 1, px + 16, px + 16};
        ys = '{py + 16, py + 16, py - 1, py - 1, py + 1, py + 14, py + 1, py + 14};
        for (int k = 0; k < 8; k++) hit[k] = m_hit(xs[k], ys[k]);
        exp_flags = {hit[6] | hit[7], hit[4] | hit[5], hit[2] | hit[3], hit[0] | hit[1]};
        have_addr = 1'b0;
        last_addr = 0;
        @(posedge clock); #1;
        scroll_x   = 10'(sx);
        y_position = 8'(y);
        enable     = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock); #1;
            if (c == 1) begin
                scroll_x   = 10'($urandom);
                y_position = 8'($urandom);
            end
            if (drop_en && c == 3) enable = 1'b0;
            if (c <= 8) begin
                check("tile_rd", tile_rd, !m_oob(ys[c - 1]));
                if (!m_oob(ys[c - 1])) begin
                    check("tile_addr", tile_addr, m_addr(xs[c - 1], ys[c - 1]));
                    last_addr = m_addr(xs[c - 1], ys[c - 1]);
                    have_addr = 1'b1;
                end else if (have_addr) begin
                    check("addr_hold", tile_addr, last_addr);
                end
            end else if (c == 9) begin
                check("rd_in_last", tile_rd, 0);
                check("done_early", done, 0);
            end else begin
                check("done", done, 1);
                check("flags", flags_now(), exp_flags);
            end
        end
        if (drop_en) begin
            @(posedge clock); #1;
            check("done_one_cycle", done, 0);
        end
    endtask

    task automatic end_txn();
        enable = 1'b0;
        @(posedge clock); #1;
        check("idle_after_drop", done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_map();
        repeat (2) @(posedge clock);
        #1;
        check("rst_done", done, 0);
        check("rst_rd", tile_rd, 0);
        check("rst_addr", tile_addr, 0);
        check("rst_flags", flags_now(), 0);
        reset = 1'b0;

        // empty map: probe 0 lands on row 8 col 9 (1033), no flags
        run_txn(0, 50, 1'b0);
        check("empty_flags", flags_now(), 4'b0000);
        end_txn();

        // floor under the character
        map_bits[8 * 128 + 9]  = 1'b1;
        map_bits[8 * 128 + 10] = 1'b1;
        run_txn(0, 50, 1'b0);
        check("floor_flags", flags_now(), 4'b0001);
        end_txn();

        // reset in the middle of PROBE clears everything immediately
        @(posedge clock); #1;
        enable = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_done", done, 0);
        check("midrst_rd", tile_rd, 0);
        check("midrst_addr", tile_addr, 0);
        check("midrst_flags", flags_now(), 0);
        enable = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("post_rst_idle_rd", tile_rd, 0);
        check("post_rst_idle_done", done, 0);

        // top edge: up probes out of bounds
        random_map(30);
        run_txn(0, 0, 1'b0);
        check("top_up", up_blocked, 1);
        end_txn();

        // horizontal wrap: left probes reach world column 0
        clear_map();
        for (int r = 0; r < 16; r++) map_bits[r * 128] = 1'b1;
        run_txn(960, 50, 1'b0);
        check("wrap_lr", {left_blocked, right_blocked}, 2'b10);
        end_txn();

        // enable dropped mid-transaction still completes with a one-cycle done
        random_map(40);
        run_txn(int'($urandom_range(0, 1023)), int'($urandom_range(0, 120)), 1'b1);

        // handshake: hold enable, mutate map, flags and done must not move
        clear_map();
        map_bits[8 * 128 + 9] = 1'b1;
        run_txn(0, 50, 1'b0);
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 2048; a++) map_bits[a] = ~map_bits[a];
            @(posedge clock); #1;
            check("hold_done", done, 1);
            check("hold_flags", flags_now(), exp_flags);
            check("hold_rd", tile_rd, 0);
        end
        end_txn();
        run_txn(100, 20, 1'b0);
        end_txn();

        for (int n = 0; n < 8; n++) begin
            random_map(25);
            run_txn(int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)), 1'b0);
            end_txn();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
